// File: rtl/etc_report_arbiter.sv
// Two-lane speed report arbiter: captures per-lane speed measurements and
// serialises them as 4-byte frames (header, lane/speed-high, speed-low,
// XOR checksum) into a UART TX FIFO. Writes are spaced by at least one idle
// cycle, and each byte stalls while the FIFO is full.
module etc_report_arbiter #(
  parameter int unsigned       WIDTH_SPEED = 14,
  parameter int unsigned       DATA_SIZE   = 8,
  parameter logic [DATA_SIZE-1:0] HEADER   = 8'hA5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   done0,
  input  logic [WIDTH_SPEED-1:0] speed0,
  input  logic                   done1,
  input  logic [WIDTH_SPEED-1:0] speed1,
  input  logic                   fifo_full,
  output logic                   write,
  output logic [DATA_SIZE-1:0]   data,
  output logic                   busy,
  output logic [1:0]             drop
);

  typedef enum logic [2:0] {IDLE, HDR, HI, LO, CHK, GAP} state_t;

  state_t                 state, state_nxt;
  // Byte state that GAP returns to (IDLE once the checksum has gone out).
  state_t                 resume, resume_nxt;
  logic                   write_nxt;
  logic [DATA_SIZE-1:0]   data_nxt;

  logic [1:0]             pending;
  logic [WIDTH_SPEED-1:0] spd [2];
  logic [WIDTH_SPEED-1:0] speed_in [2];
  logic [1:0]             done_v;
  logic                   last_grant;

  logic                   grant;
  logic                   grant_lane;
  logic                   lane;
  logic [13:0]            snap;

  logic [DATA_SIZE-1:0]   hi_b, lo_b, chk_b, byte_cur;
  state_t                 follow;

  assign done_v      = {done1, done0};
  assign speed_in[0] = speed0;
  assign speed_in[1] = speed1;
  assign busy        = (state != IDLE);

  // Round-robin: a lone pending lane wins; with both pending, the lane not granted last time wins.
  assign grant      = (state == IDLE) && (|pending);
  assign grant_lane = (pending == 2'b11) ? ~last_grant : pending[1];

  assign hi_b  = {lane, 1'b0, snap[13:8]};
  assign lo_b  = snap[7:0];
  assign chk_b = HEADER ^ hi_b ^ lo_b;

  // Frame FSM state, resume point and registered FIFO outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      resume <= IDLE;
      write  <= 1'b0;
      data   <= '0;
    end else begin
      state  <= state_nxt;
      resume <= resume_nxt;
      write  <= write_nxt;
      data   <= data_nxt;
    end
  end

  // Next-state and next-output decode; a byte state either emits or stalls on fifo_full.
  always_comb begin
    state_nxt  = state;
    resume_nxt = resume;
    write_nxt  = 1'b0;
    data_nxt   = data;
    byte_cur   = '0;
    follow     = IDLE;
    case (state)
      IDLE: if (grant) state_nxt = HDR;
      HDR:  begin byte_cur = HEADER; follow = HI;   end
      HI:   begin byte_cur = hi_b;   follow = LO;   end
      LO:   begin byte_cur = lo_b;   follow = CHK;  end
      CHK:  begin byte_cur = chk_b;  follow = IDLE; end
      GAP:  state_nxt = resume;
      default: state_nxt = IDLE;
    endcase
    if ((state == HDR || state == HI || state == LO || state == CHK) && !fifo_full) begin
      write_nxt  = 1'b1;
      data_nxt   = byte_cur;
      resume_nxt = follow;
      state_nxt  = GAP;
    end
  end

  // Grant bookkeeping: frame snapshot (held for the whole frame) and round-robin history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane       <= 1'b0;
      snap       <= '0;
      last_grant <= 1'b1;
    end else if (grant) begin
      lane       <= grant_lane;
      snap       <= 14'(spd[grant_lane]);
      last_grant <= grant_lane;
    end
  end

  // Per-lane pending capture; a new done beats a same-edge grant clear, otherwise overflows drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      drop    <= '0;
      spd[0]  <= '0;
      spd[1]  <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        drop[i] <= 1'b0;
        if (done_v[i]) begin
          if (pending[i] && !(grant && (grant_lane == 1'(i)))) begin
            drop[i] <= 1'b1;
          end else begin
            pending[i] <= 1'b1;
            spd[i]     <= speed_in[i];
          end
        end else if (grant && (grant_lane == 1'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_etc_report_arbiter.sv
// Bench for etc_report_arbiter: a frame-level reference model predicts every
// output each cycle; directed scenarios pin literal frame bytes and timing.
module tb_etc_report_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        done0, done1, fifo_full;
  logic [13:0] speed0, speed1;
  logic        write;
  logic [7:0]  data;
  logic        busy;
  logic [1:0]  drop;

  int checks = 0;
  int errors = 0;

  etc_report_arbiter #(.WIDTH_SPEED(14), .DATA_SIZE(8), .HEADER(8'hA5)) dut (
    .clk(clk), .reset(reset), .done0(done0), .speed0(speed0),
    .done1(done1), .speed1(speed1), .fifo_full(fifo_full),
    .write(write), .data(data), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending reports per lane, and the frame in flight as a byte list.
  int          m_pend [2];
  logic [13:0] m_spd [2];
  int          m_last;
  bit          m_active;
  bit          m_gap;
  int          m_k;
  logic [7:0]  m_fb [4];
  logic        m_write;
  logic [7:0]  m_data;
  logic [1:0]  m_drop;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend[0] = 0; m_pend[1] = 0;
      m_spd[0] = '0; m_spd[1] = '0;
      m_last = 1; m_active = 0; m_gap = 0; m_k = 0;
      m_write = 0; m_data = '0; m_drop = '0;
    end else begin
      int g;
      logic [1:0]  d;
      logic [13:0] sp [2];
      g = -1;
      d = {done1, done0};
      sp[0] = speed0; sp[1] = speed1;
      if (!m_active) begin
        m_write = 0;
        if (m_pend[0] != 0 || m_pend[1] != 0) begin
          if (m_pend[0] != 0 && m_pend[1] != 0) g = 1 - m_last;
          else g = (m_pend[1] != 0) ? 1 : 0;
          m_last = g;
          m_fb[0] = 8'hA5;
          m_fb[1] = 8'((g * 128) + (m_spd[g] / 256));
          m_fb[2] = 8'(m_spd[g] % 256);
          m_fb[3] = m_fb[0] ^ m_fb[1] ^ m_fb[2];
          m_active = 1; m_k = 0; m_gap = 0;
        end
      end else if (!m_gap) begin
        if (!fifo_full) begin
          m_write = 1; m_data = m_fb[m_k]; m_gap = 1;
        end else begin
          m_write = 0;
        end
      end else begin
        m_write = 0; m_gap = 0;
        if (m_k == 3) m_active = 0;
        else m_k++;
      end
      for (int l = 0; l < 2; l++) begin
        m_drop[l] = 1'b0;
        if (d[l]) begin
          if (m_pend[l] != 0 && g != l) m_drop[l] = 1'b1;
          else begin m_pend[l] = 1; m_spd[l] = sp[l]; end
        end else if (g == l) begin
          m_pend[l] = 0;
        end
      end
    end
  end

  logic [7:0] wlog [$];
  int         busy_cnt;
  int         drop1_cnt;
  logic       prev_write = 1'b0;

  // Compare process: every negedge, DUT outputs against the model.
  always @(negedge clk) begin
    check("write", 32'(write), 32'(m_write));
    check("data",  32'(data),  32'(m_data));
    check("busy",  32'(busy),  32'(m_active));
    check("drop",  32'(drop),  32'(m_drop));
    check("no_back_to_back", 32'(write && prev_write), 32'(0));
    prev_write = write;
    if (write) wlog.push_back(data);
    if (busy) busy_cnt++;
    if (drop[1]) drop1_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; done0 = 1'b0; done1 = 1'b0; fifo_full = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    wlog.delete(); busy_cnt = 0; drop1_cnt = 0;
  endtask

  task automatic check_log(input string name, input logic [7:0] exp [$]);
    check({name, "_len"}, 32'(wlog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wlog.size(); i++)
      check({name, "_byte"}, 32'(wlog[i]), 32'(exp[i]));
  endtask

  initial begin
    reset = 1'b1; done0 = 1'b0; done1 = 1'b0; fifo_full = 1'b0;
    speed0 = '0; speed1 = '0;
    busy_cnt = 0; drop1_cnt = 0;
    tick();
    check("reset_write", 32'(write), 32'(0));
    check("reset_busy",  32'(busy),  32'(0));
    check("reset_data",  32'(data),  32'(0));

    // Single lane 0 report, no stall.
    do_reset();
    done0 = 1'b1; speed0 = 14'h0123; tick(); done0 = 1'b0;
    repeat (12) tick();
    check_log("lane0_frame", '{8'hA5, 8'h01, 8'h23, 8'h87});
    check("lane0_busy_cycles", 32'(busy_cnt), 32'(8));

    // Both lanes at once after reset: lane 0 first.
    do_reset();
    done0 = 1'b1; speed0 = 14'h0010; done1 = 1'b1; speed1 = 14'h3FFF;
    tick(); done0 = 1'b0; done1 = 1'b0;
    repeat (22) tick();
    check_log("both_frames", '{8'hA5, 8'h00, 8'h10, 8'hB5, 8'hA5, 8'hBF, 8'hFF, 8'hE5});

    // FIFO full for 10 cycles while the LO byte is due.
    do_reset();
    done0 = 1'b1; speed0 = 14'h0123; tick(); done0 = 1'b0;
    repeat (5) tick();
    fifo_full = 1'b1;
    repeat (10) tick();
    check("stall_no_write", 32'(wlog.size()), 32'(2));
    fifo_full = 1'b0;
    repeat (10) tick();
    check_log("stall_frame", '{8'hA5, 8'h01, 8'h23, 8'h87});

    // Lane 1 overrun while lane 0 frames.
    do_reset();
    done0 = 1'b1; speed0 = 14'h0005; tick(); done0 = 1'b0;
    tick();
    done1 = 1'b1; speed1 = 14'h0111; tick(); done1 = 1'b0;
    tick();
    done1 = 1'b1; speed1 = 14'h0222; tick(); done1 = 1'b0;
    repeat (20) tick();
    check("drop1_pulses", 32'(drop1_cnt), 32'(1));
    check_log("overrun_frames", '{8'hA5, 8'h00, 8'h05, 8'hA0, 8'hA5, 8'h81, 8'h11, 8'h35});

    // Reset in the middle of a frame (HI byte pending).
    do_reset();
    done0 = 1'b1; speed0 = 14'h0123; tick(); done0 = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("midreset_write", 32'(write), 32'(0));
    check("midreset_data",  32'(data),  32'(0));
    check("midreset_busy",  32'(busy),  32'(0));
    check("midreset_drop",  32'(drop),  32'(0));
    tick(); tick();
    reset = 1'b0;
    wlog.delete();
    repeat (12) tick();
    check("after_reset_silent", 32'(wlog.size()), 32'(0));

    // Randomised traffic, checked cycle by cycle against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      done0     = ($urandom_range(0, 7) == 0);
      done1     = ($urandom_range(0, 7) == 0);
      speed0    = 14'($urandom);
      speed1    = 14'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      tick();
    end
    done0 = 1'b0; done1 = 1'b0; fifo_full = 1'b0;
    repeat (40) tick();
    check("drain_idle", 32'(busy), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
